// File: rtl/turn_scheduler_if.sv
// Control-unit <-> turn scheduler handshake bundle: setup, move/miss requests,
// and the board-state view read by the display datapath.
interface turn_scheduler_if;
    logic       cfg_we;
    logic [3:0] key;
    logic       start;
    logic       move_req;
    logic       miss_req;
    logic       ready;
    logic       ack;
    logic [2:0] num_players;
    logic [1:0] cur_player;
    logic [4:0] cur_pos;
    logic [2:0] cur_tails;
    logic       win;
    logic [1:0] winner;
    logic [2:0] state;

    modport master (
        output cfg_we, key, start, move_req, miss_req,
        input  ready, ack, num_players, cur_player, cur_pos, cur_tails, win, winner, state
    );

    modport slave (
        input  cfg_we, key, start, move_req, miss_req,
        output ready, ack, num_players, cur_player, cur_pos, cur_tails, win, winner, state
    );
endinterface

// File: rtl/turn_scheduler.sv
// Chicken-game turn scheduler: owns player positions/tails, rotates turns,
// applies moves with captures and raises a sticky win flag.
module turn_scheduler #(
    parameter int TRACK_LEN = 24,
    parameter int SPACING   = 6
) (
    input logic             clk,
    input logic             rst,
    turn_scheduler_if.slave sched_if
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CONFIG = 3'd1,
        S_PLAY   = 3'd2,
        S_MOVE   = 3'd3,
        S_CHECK  = 3'd4,
        S_NEXT   = 3'd5,
        S_WIN    = 3'd6
    } state_e;

    localparam logic [4:0] TRACK_END = 5'(TRACK_LEN);

    state_e     state_q, state_d;
    logic [2:0] num_q, num_d;
    logic [1:0] cur_q, cur_d;
    logic [4:0] pos_q   [4];
    logic [4:0] pos_d   [4];
    logic [2:0] tails_q [4];
    logic [2:0] tails_d [4];
    logic       ready_q, ready_d;
    logic       ack_q, ack_d;
    logic       win_q, win_d;
    logic [1:0] winner_q, winner_d;
    logic [4:0] cur_pos_q;
    logic [2:0] cur_tails_q;

    logic [2:0] cap_tails;
    logic [4:0] pos_inc;
    logic [1:0] step;
    logic [1:0] next_cur;
    logic       found;

    function automatic logic [1:0] wrap_inc(input logic [1:0] p, input logic [2:0] n);
        return ({1'b0, p} == n - 3'd1) ? 2'd0 : p + 2'd1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d   = state_q;
        num_d     = num_q;
        cur_d     = cur_q;
        pos_d     = pos_q;
        tails_d   = tails_q;
        ack_d     = 1'b0;
        win_d     = win_q;
        winner_d  = winner_q;
        cap_tails = tails_q[cur_q];
        pos_inc   = pos_q[cur_q] + 5'd1;
        step      = cur_q;
        next_cur  = cur_q;
        found     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sched_if.cfg_we) state_d = S_CONFIG;
            end
            S_CONFIG: begin
                if (sched_if.cfg_we && sched_if.key >= 4'd2 && sched_if.key <= 4'd4)
                    num_d = sched_if.key[2:0];
                if (sched_if.start && num_q != 3'd0) begin
                    state_d = S_PLAY;
                    cur_d   = 2'd0;
                    for (int i = 0; i < 4; i++) begin
                        if (3'(i) < num_q) begin
                            pos_d[i]   = 5'(i * SPACING);
                            tails_d[i] = 3'd1;
                        end else begin
                            pos_d[i]   = 5'd0;
                            tails_d[i] = 3'd0;
                        end
                    end
                end
            end
            S_PLAY: begin
                // move wins a same-cycle collision; the miss is dropped
                if (ready_q && sched_if.move_req)      state_d = S_MOVE;
                else if (ready_q && sched_if.miss_req) state_d = S_NEXT;
            end
            S_MOVE: begin
                pos_d[cur_q] = (pos_inc == TRACK_END) ? 5'd0 : pos_inc;
                state_d      = S_CHECK;
            end
            S_CHECK: begin
                for (int j = 0; j < 4; j++) begin
                    if (2'(j) != cur_q && 3'(j) < num_q && tails_q[j] != 3'd0 &&
                        pos_q[j] == pos_q[cur_q]) begin
                        cap_tails  = cap_tails + tails_q[j];
                        tails_d[j] = 3'd0;
                    end
                end
                tails_d[cur_q] = cap_tails;
                ack_d          = 1'b1;
                if (cap_tails == num_q) begin
                    win_d    = 1'b1;
                    winner_d = cur_q;
                    state_d  = S_WIN;
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_NEXT: begin
                // first player after cur that still holds tails
                for (int k = 0; k < 3; k++) begin
                    step = wrap_inc(step, num_q);
                    if (!found && tails_q[step] != 3'd0) begin
                        next_cur = step;
                        found    = 1'b1;
                    end
                end
                cur_d   = next_cur;
                ack_d   = 1'b1;
                state_d = S_PLAY;
            end
            S_WIN: begin
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ready stays low through the ack cycle so one request completes per handshake
    assign ready_d = (state_d == S_PLAY) && !ack_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q       <= 3'd0;
            cur_q       <= 2'd0;
            ready_q     <= 1'b0;
            ack_q       <= 1'b0;
            win_q       <= 1'b0;
            winner_q    <= 2'd0;
            cur_pos_q   <= 5'd0;
            cur_tails_q <= 3'd0;
            // NOTE: the board arrays are reset because a reset game must show
            // zeroed positions/tails; they are small flops, not RAM.
            for (int i = 0; i < 4; i++) begin
                pos_q[i]   <= 5'd0;
                tails_q[i] <= 3'd0;
            end
        end else begin
            num_q       <= num_d;
            cur_q       <= cur_d;
            ready_q     <= ready_d;
            ack_q       <= ack_d;
            win_q       <= win_d;
            winner_q    <= winner_d;
            cur_pos_q   <= pos_d[cur_d];
            cur_tails_q <= tails_d[cur_d];
            for (int i = 0; i < 4; i++) begin
                pos_q[i]   <= pos_d[i];
                tails_q[i] <= tails_d[i];
            end
        end
    end

    assign sched_if.ready       = ready_q;
    assign sched_if.ack         = ack_q;
    assign sched_if.num_players = num_q;
    assign sched_if.cur_player  = cur_q;
    assign sched_if.cur_pos     = cur_pos_q;
    assign sched_if.cur_tails   = cur_tails_q;
    assign sched_if.win         = win_q;
    assign sched_if.winner      = winner_q;
    assign sched_if.state       = state_q;

endmodule
